// File: rtl/alien_march_ctrl.sv
// Formation march controller: frame-tick pacing, march/drop sequencing and
// invasion detection; emits a one-cycle step strobe with X/Y offsets.
module alien_march_ctrl #(
  parameter int H_LAST      = 639,
  parameter int V_LAST      = 479,
  parameter int X_STEP      = 2,
  parameter int Y_STEP      = 3,
  parameter int DROP_STEPS  = 4,
  parameter int LEFT_LIMIT  = 5,
  parameter int RIGHT_LIMIT = 603,
  parameter int GROUND_Y    = 420,
  parameter int MIN_PERIOD  = 1,
  parameter int SPEED_SHIFT = 2
) (
  input  logic       Pclk,
  input  logic       rst_n,
  input  logic [9:0] xx,
  input  logic [9:0] yy,
  input  logic       run,
  input  logic [9:0] form_left,
  input  logic [9:0] form_right,
  input  logic [9:0] form_bottom,
  input  logic [5:0] alive_cnt,
  output logic [1:0] X_off,
  output logic [1:0] Y_off,
  output logic       dir_left,
  output logic       step,
  output logic       invaded
);

  typedef enum logic [1:0] {MARCH_R, DROP_L, MARCH_L, DROP_R} state_t;

  state_t     state_q, state_d;
  logic [6:0] frame_q, frame_d;
  logic [7:0] drop_q, drop_d;
  logic       step_q, step_d;
  logic [1:0] x_off_q, x_off_d;
  logic [1:0] y_off_q, y_off_d;
  logic       dir_q, dir_d;
  logic       inv_q, inv_d;

  logic       tick;
  logic       active;
  logic       fire;
  logic [6:0] period;

  assign tick   = (xx == 10'(H_LAST)) && (yy == 10'(V_LAST));
  assign period = 7'(MIN_PERIOD) + 7'(alive_cnt >> SPEED_SHIFT);
  assign active = tick && run && !inv_q && (alive_cnt != 6'd0);
  // >= rather than == so a shrinking period fires at once instead of wrapping
  assign fire   = active && (({1'b0, frame_q} + 8'd1) >= {1'b0, period});

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    drop_d  = drop_q;
    dir_d   = dir_q;
    inv_d   = inv_q;
    step_d  = 1'b0;
    x_off_d = 2'd0;
    y_off_d = 2'd0;

    if (active) frame_d = fire ? 7'd0 : frame_q + 7'd1;
    if (tick && (form_bottom >= 10'(GROUND_Y))) inv_d = 1'b1;

    if (fire) begin
      step_d = 1'b1;
      unique case (state_q)
        MARCH_R: begin
          if (form_right >= 10'(RIGHT_LIMIT)) begin
            state_d = DROP_L;
            drop_d  = 8'd0;
            y_off_d = 2'(Y_STEP);
          end else begin
            x_off_d = 2'(X_STEP);
            dir_d   = 1'b0;
          end
        end
        MARCH_L: begin
          if (form_left <= 10'(LEFT_LIMIT)) begin
            state_d = DROP_R;
            drop_d  = 8'd0;
            y_off_d = 2'(Y_STEP);
          end else begin
            x_off_d = 2'(X_STEP);
            dir_d   = 1'b1;
          end
        end
        DROP_L, DROP_R: begin
          y_off_d = 2'(Y_STEP);
          drop_d  = drop_q + 8'd1;
          // entry step already counted, so exit when this is drop DROP_STEPS
          if ((drop_q + 8'd2) >= 8'(DROP_STEPS)) begin
            drop_d  = 8'd0;
            state_d = (state_q == DROP_L) ? MARCH_L : MARCH_R;
            dir_d   = (state_q == DROP_L);
          end
        end
        default: state_d = MARCH_R;
      endcase
    end
  end

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MARCH_R;
      frame_q <= 7'd0;
      drop_q  <= 8'd0;
      step_q  <= 1'b0;
      x_off_q <= 2'd0;
      y_off_q <= 2'd0;
      dir_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
      step_q  <= step_d;
      x_off_q <= x_off_d;
      y_off_q <= y_off_d;
      dir_q   <= dir_d;
      inv_q   <= inv_d;
    end
  end

  assign step     = step_q;
  assign X_off    = x_off_q;
  assign Y_off    = y_off_q;
  assign dir_left = dir_q;
  assign invaded  = inv_q;

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Self-checking bench for alien_march_ctrl: directed scenarios plus random
// frames compared against a step-rule reference model.
module tb_alien_march_ctrl;

  localparam int H_LAST = 639;
  localparam int V_LAST = 479;

  logic       Pclk = 1'b0;
  logic       rst_n;
  logic [9:0] xx, yy;
  logic       run;
  logic [9:0] form_left, form_right, form_bottom;
  logic [5:0] alive_cnt;
  logic [1:0] X_off, Y_off;
  logic       dir_left, step, invaded;

  alien_march_ctrl dut (
    .Pclk(Pclk), .rst_n(rst_n), .xx(xx), .yy(yy), .run(run),
    .form_left(form_left), .form_right(form_right), .form_bottom(form_bottom),
    .alive_cnt(alive_cnt), .X_off(X_off), .Y_off(Y_off),
    .dir_left(dir_left), .step(step), .invaded(invaded)
  );

  always #5 Pclk = ~Pclk;

  int errors = 0;
  int checks = 0;
  int nsteps = 0;

  // reference model: frames since last step, direction, drops still owed
  int m_frames, m_dir, m_drops_left, m_inv;
  int e_step, e_x, e_y;

  function automatic void model_reset();
    m_frames = 0; m_dir = 0; m_drops_left = 0; m_inv = 0;
  endfunction

  function automatic void model_tick();
    int  period;
    bit  act, fire;
    period = 1 + (int'(alive_cnt) / 4);
    act    = run && (m_inv == 0) && (alive_cnt != 0);
    fire   = act && (m_frames + 1 >= period);
    if (act) m_frames = fire ? 0 : m_frames + 1;
    e_step = fire; e_x = 0; e_y = 0;
    if (fire) begin
      if (m_drops_left > 0) begin
        e_y = 3;
        m_drops_left--;
        if (m_drops_left == 0) m_dir = 1 - m_dir;
      end else if ((m_dir == 0 && form_right >= 603) || (m_dir == 1 && form_left <= 5)) begin
        e_y = 3;
        m_drops_left = 3;
      end else begin
        e_x = 2;
      end
    end
    if (form_bottom >= 420) m_inv = 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    @(negedge Pclk);
    xx = 10'(H_LAST); yy = 10'(V_LAST);
    model_tick();
    @(negedge Pclk);
    xx = 10'd0; yy = 10'd0;
    chk("step", step, e_step);
    chk("x_off", X_off, e_x);
    chk("y_off", Y_off, e_y);
    chk("dir_left", dir_left, m_dir);
    chk("invaded", invaded, m_inv);
    if (step) nsteps++;
    @(negedge Pclk);
    chk("step_width", step, 0);
    chk("x_off_idle", X_off, 0);
    chk("y_off_idle", Y_off, 0);
  endtask

  task automatic reset_pulse();
    @(negedge Pclk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_step", step, 0);
    chk("rst_x_off", X_off, 0);
    chk("rst_y_off", Y_off, 0);
    chk("rst_dir", dir_left, 0);
    chk("rst_invaded", invaded, 0);
    @(negedge Pclk);
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; xx = 10'd0; yy = 10'd0; run = 1'b1;
    form_left = 10'd300; form_right = 10'd100; form_bottom = 10'd100;
    alive_cnt = 6'd4;
    model_reset();
    repeat (3) @(negedge Pclk);
    chk("reset_step", step, 0);
    chk("reset_x_off", X_off, 0);
    chk("reset_y_off", Y_off, 0);
    chk("reset_dir", dir_left, 0);
    chk("reset_invaded", invaded, 0);
    rst_n = 1'b1;

    // period 2: four ticks give two steps
    nsteps = 0;
    repeat (4) frame();
    chk("basic_step_count", nsteps, 2);

    // right edge: four drops then march left
    form_right = 10'd603;
    nsteps = 0;
    repeat (8) frame();
    chk("drop_r_steps", nsteps, 4);
    chk("dir_after_drop_l", dir_left, 1);
    form_right = 10'd100;
    repeat (2) frame();

    // left edge: four drops then march right
    form_left = 10'd5;
    repeat (8) frame();
    chk("dir_after_drop_r", dir_left, 0);
    form_left = 10'd300;
    repeat (2) frame();

    // speed-up mid-count
    alive_cnt = 6'd55;
    guard = 0;
    while (m_frames != 10 && guard < 30) begin frame(); guard++; end
    chk("speed_reach_count10", m_frames, 10);
    alive_cnt = 6'd3;
    nsteps = 0;
    repeat (4) frame();
    chk("speed_every_tick", nsteps, 4);

    // run=0 freezes the count
    alive_cnt = 6'd20;
    guard = 0;
    while (m_frames != 0 && guard < 10) begin frame(); guard++; end
    repeat (2) frame();
    run = 1'b0;
    nsteps = 0;
    repeat (5) frame();
    chk("run0_no_step", nsteps, 0);
    run = 1'b1;
    repeat (4) frame();
    chk("run1_resume", nsteps, 1);

    // reset in the middle of a drop
    alive_cnt = 6'd4; form_right = 10'd603;
    guard = 0;
    while (m_drops_left == 0 && guard < 10) begin frame(); guard++; end
    chk("entered_drop", m_drops_left, 3);
    reset_pulse();
    form_right = 10'd100;
    repeat (2) frame();
    chk("post_reset_march_r", nsteps >= 1, 1);

    // randomized frames
    for (int i = 0; i < 150; i++) begin
      run         = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) alive_cnt = 6'($urandom_range(0, 55));
      else if (alive_cnt > 6'd15) alive_cnt = 6'($urandom_range(0, 15));
      form_right  = 10'($urandom_range(560, 610));
      form_left   = 10'($urandom_range(0, 40));
      form_bottom = 10'($urandom_range(0, 419));
      frame();
    end

    // invasion, then asynchronous reset between ticks
    run = 1'b1; alive_cnt = 6'd3; form_bottom = 10'd420;
    frame();
    chk("invaded_set", invaded, 1);
    form_bottom = 10'd100;
    nsteps = 0;
    repeat (3) frame();
    chk("invaded_no_step", nsteps, 0);
    reset_pulse();
    form_right = 10'd100; form_left = 10'd300;
    repeat (2) frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alien_march_ctrl.md
Name: alien_march_ctrl

Overview:
- Formation-level march controller sitting directly upstream of the per-alien movement blocks.
- Counts frames and decides when the alien formation steps, in which direction, and when it drops a row.
- Broadcasts a one-cycle step strobe with X/Y offsets that every alien movement block applies to its own position.
- Speeds up as aliens die, and flags an invasion when the formation reaches the ground line.

Parameters:
- H_LAST, 639, last active pixel column; frame tick fires at (H_LAST, V_LAST).
- V_LAST, 479, last active pixel row.
- X_STEP, 2, horizontal step magnitude in pixels; must fit 2 bits.
- Y_STEP, 3, vertical drop per drop step in pixels; must fit 2 bits.
- DROP_STEPS, 4, number of drop steps per row change.
- LEFT_LIMIT, 5, march reverses when formation left edge <= this.
- RIGHT_LIMIT, 603, march reverses when formation right edge >= this.
- GROUND_Y, 420, invasion when formation bottom >= this.
- MIN_PERIOD, 1, minimum frames between steps.
- SPEED_SHIFT, 2, period = MIN_PERIOD + (alive_cnt >> SPEED_SHIFT).

Ports:
- Pclk  input  1  pixel clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- xx  input  10  current pixel column from VGA timing.
- yy  input  10  current pixel row from VGA timing.
- run  input  1  1 = game playing; 0 = formation frozen.
- form_left  input  10  leftmost x of any live alien.
- form_right  input  10  rightmost x+width of any live alien.
- form_bottom  input  10  lowest y+height of any live alien.
- alive_cnt  input  6  number of live aliens, 0..55.
- X_off  output  2  horizontal step magnitude; valid only while step is 1, else 0.
- Y_off  output  2  vertical step; valid only while step is 1, else 0.
- dir_left  output  1  1 = current march direction is left.
- step  output  1  one-cycle strobe: movement blocks apply X_off/Y_off on this cycle.
- invaded  output  1  sticky; formation reached GROUND_Y.

Behaviour:
- Reset (async, rst_n=0):
  - state=MARCH_R, dir_left=0, step=0, X_off=0, Y_off=0, invaded=0.
  - frame counter = 0, drop counter = 0.
  - Release is synchronous to the next Pclk edge.
- Frame tick:
  - Internal one-cycle tick when xx==H_LAST && yy==V_LAST.
  - Every other block action occurs only on a tick cycle, registered.
  - step, X_off and Y_off are asserted in the cycle after the tick.
- Period:
  - period = MIN_PERIOD + (alive_cnt >> SPEED_SHIFT), 7-bit arithmetic, no overflow.
  - period is sampled at each tick.
  - The frame counter increments on each tick while run=1 and invaded=0.
  - When the counter >= period-1, the counter is cleared and a step is issued.
  - Because the comparison is >=, a period decrease mid-count never skips below 1 frame.
- States:
  - MARCH_R, on a step:
    - if form_right >= RIGHT_LIMIT: go to DROP_L, drop counter = 0; this step emits X_off=0, Y_off=Y_STEP.
    - else emit X_off=X_STEP, Y_off=0, dir_left=0.
  - DROP_L, each step:
    - emit X_off=0, Y_off=Y_STEP; drop counter +1.
    - after DROP_STEPS drop steps in total (including the entry step), go to MARCH_L and set dir_left=1.
  - MARCH_L: mirror of MARCH_R, using form_left <= LEFT_LIMIT and next state DROP_R.
  - DROP_R: mirror of DROP_L; exits to MARCH_R with dir_left=0.
- Both edges satisfied simultaneously (formation wider than the field): the current state's own edge test wins, so no oscillation within a step.
- Invasion:
  - On any tick with form_bottom >= GROUND_Y, invaded is set to 1.
  - It stays 1 until reset.
  - While invaded=1: no further steps, and the state is frozen.
- alive_cnt==0: steps stop (period irrelevant), the state is held, and invaded is unchanged.
- run=0:
  - The counter and state hold; no step is issued.
  - When run returns to 1, counting resumes from the held value.
- Reset mid-drop: everything returns to MARCH_R; a partial drop is abandoned.
- X_off/Y_off are forced to 0 in every cycle where step=0.

Test Plan:
- Reset, run=1, alive_cnt=0→1 is not used; set alive_cnt=4 (period=2), form_right=100, drive 4 frame ticks -> exactly 2 step pulses, each 1 cycle wide, X_off=2, Y_off=0, dir_left=0.
- MARCH_R with form_right=603 at the step -> 4 consecutive steps with X_off=0, Y_off=3; then dir_left=1; the next step has X_off=2, dir_left=1.
- MARCH_L with form_left=5 -> drop sequence of 4 steps, then dir_left=0.
- alive_cnt from 55 (period 14) to 3 (period 1) mid-count with the counter at 10 -> a step on the next tick, then a step on every tick.
- form_bottom=420 on a tick -> invaded=1 on the next cycle, no further step; pulse rst_n low between ticks -> invaded=0, state MARCH_R, immediately and asynchronously.
- run=0 for 5 ticks mid-count -> no step; when run=1, the step arrives after the remaining frames only.
